// File: rtl/mic_pkg.sv
// Shared constants and state type for the MIC microsequencer.
// Optional breakpoint support is enabled with MIC_SEQ_BREAK_EN.
package mic_pkg;

    localparam int unsigned JAM_JMPC  = 32'd2;
    localparam int unsigned JAM_JAMN  = 32'd1;
    localparam int unsigned JAM_JAMZ  = 32'd0;
    localparam int unsigned MEM_FETCH = 32'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MBR = 2'd1,
        HALT     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mic_next_addr.sv
// Combinational next-MPC computation: JAMN/JAMZ OR into bit 8, JMPC ORs MBR into the low byte.
module mic_next_addr
    import mic_pkg::*;
(
    input  logic [8:0] next_addr,
    input  logic [2:0] jam,
    input  logic       n_q,
    input  logic       z_q,
    input  logic [7:0] mbr,
    output logic [8:0] nxt
);

    logic       hi_s;
    logic [7:0] lo_s;

    // Bit 8 and low byte are formed independently, so the result never carries.
    always_comb begin
        hi_s = next_addr[8] | (jam[JAM_JAMN] & n_q) | (jam[JAM_JAMZ] & z_q);
        if (jam[JAM_JMPC]) begin
            lo_s = next_addr[7:0] | mbr;
        end else begin
            lo_s = next_addr[7:0];
        end
        nxt = {hi_s, lo_s};
    end

endmodule

// File: rtl/mic_sequencer.sv
// MIC microsequencer: owns MPC, latches ALU flags, and stalls JMPC until the opcode byte arrives.
// Define MIC_SEQ_BREAK_EN to add the breakpoint ports and the HALT state.
module mic_sequencer
    import mic_pkg::*;
#(
    parameter logic [8:0] RESET_ADDR = 9'h000
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MIC_SEQ_BREAK_EN
    input  logic [8:0] brk_addr,
    input  logic       resume,
    output logic       brk_hit,
`endif
    input  logic [8:0] next_addr,
    input  logic [2:0] jam,
    input  logic [2:0] mem,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic [7:0] mbr,
    input  logic       mbr_valid,
    output logic [8:0] mpc,
    output logic       rom_read,
    output logic       stall,
    output logic       fetch_overrun
);

    seq_state_t state_r;
    seq_state_t state_nxt_s;
    logic [8:0] mpc_r;
    logic       n_r;
    logic       z_r;
    logic       fetch_pend_r;
    logic       pend_nxt_s;
    logic [8:0] nxt_s;
    logic       stall_raw_s;
    logic       stall_s;
    logic       load_s;
    logic       match_s;
    logic       unused_mem_s;

    assign unused_mem_s = ^mem[2:1];

    mic_next_addr u_next_addr (
        .next_addr (next_addr),
        .jam       (jam),
        .n_q       (n_r),
        .z_q       (z_r),
        .mbr       (mbr),
        .nxt       (nxt_s)
    );

    // Stall request per state; a JMPC only waits for a fetch that was already pending.
    always_comb begin
        stall_raw_s = 1'b0;
        case (state_r)
            RUN: begin
                if (jam[JAM_JMPC] && fetch_pend_r && !mbr_valid) begin
                    stall_raw_s = 1'b1;
                end else begin
                    stall_raw_s = 1'b0;
                end
            end
            WAIT_MBR: stall_raw_s = ~mbr_valid;
`ifdef MIC_SEQ_BREAK_EN
            HALT:     stall_raw_s = 1'b1;
`endif
            default:  stall_raw_s = 1'b0;
        endcase
    end

    assign stall_s = reset & stall_raw_s;
    assign load_s  = ~stall_s;

`ifdef MIC_SEQ_BREAK_EN
    logic brk_hit_r;
    logic brk_skip_r;

    assign match_s = load_s && (nxt_s == brk_addr) && !brk_skip_r;
    assign brk_hit = brk_hit_r;

    // Breakpoint hit pulse and one-shot suppression after resume.
    always_ff @(posedge clk) begin
        if (!reset) begin
            brk_hit_r  <= 1'b0;
            brk_skip_r <= 1'b0;
        end else begin
            brk_hit_r <= match_s;
            if ((state_r == HALT) && resume) begin
                brk_skip_r <= 1'b1;
            end else if (load_s) begin
                brk_skip_r <= 1'b0;
            end else begin
                brk_skip_r <= brk_skip_r;
            end
        end
    end
`else
    assign match_s = 1'b0;
`endif

    // State transitions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (stall_s) begin
                    state_nxt_s = WAIT_MBR;
                end else if (match_s) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            WAIT_MBR: begin
                if (!mbr_valid) begin
                    state_nxt_s = WAIT_MBR;
                end else if (match_s) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
`ifdef MIC_SEQ_BREAK_EN
            HALT: begin
                if (resume) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALT;
                end
            end
`endif
            default: state_nxt_s = RUN;
        endcase
    end

    // A new fetch outranks a completion on the same edge: the new one is now pending.
    always_comb begin
        if (mem[MEM_FETCH] && !stall_s) begin
            pend_nxt_s = 1'b1;
        end else if (mbr_valid) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = fetch_pend_r;
        end
    end

    // MPC, flags, fetch tracking and state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= RUN;
            mpc_r        <= RESET_ADDR;
            n_r          <= 1'b0;
            z_r          <= 1'b0;
            fetch_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fetch_pend_r <= pend_nxt_s;
            if (load_s) begin
                mpc_r <= nxt_s;
                n_r   <= alu_n;
                z_r   <= alu_z;
            end else begin
                mpc_r <= mpc_r;
                n_r   <= n_r;
                z_r   <= z_r;
            end
        end
    end

    assign mpc           = mpc_r;
    assign stall         = stall_s;
    assign rom_read      = ~stall_s;
    assign fetch_overrun = reset & mem[MEM_FETCH] & fetch_pend_r & ~mbr_valid & ~stall_s;

endmodule

// File: tb/tb_mic_sequencer.sv
// Bench for mic_sequencer: directed table of spec scenarios, then randomized traffic against a reference model.
module tb_mic_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] next_addr;
    logic [2:0] jam;
    logic [2:0] mem;
    logic       alu_n;
    logic       alu_z;
    logic [7:0] mbr;
    logic       mbr_valid;
    logic [8:0] mpc;
    logic       rom_read;
    logic       stall;
    logic       fetch_overrun;

    always #5 clk = ~clk;

    mic_sequencer #(.RESET_ADDR(9'h000)) dut (
        .clk           (clk),
        .reset         (reset),
        .next_addr     (next_addr),
        .jam           (jam),
        .mem           (mem),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .mbr           (mbr),
        .mbr_valid     (mbr_valid),
        .mpc           (mpc),
        .rom_read      (rom_read),
        .stall         (stall),
        .fetch_overrun (fetch_overrun)
    );

    typedef struct {
        logic       rst;
        logic [8:0] na;
        logic [2:0] jam;
        logic [2:0] mem;
        logic       az;
        logic [7:0] mbr;
        logic       mv;
        logic       chk_mpc;
        logic [8:0] e_mpc;
        logic       e_stall;
        logic       e_ovr;
    } vec_t;

    localparam int NTBL = 22;
    vec_t tbl[NTBL];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, in terms of the spec's architectural quantities.
    int m_mpc;
    bit m_n, m_z, m_pend, m_wait, m_valid, m_last_stall;

    function automatic vec_t mk(logic rst, logic [8:0] na, logic [2:0] j, logic [2:0] m, logic az,
                                logic [7:0] b, logic mv, logic cm, logic [8:0] em, logic es, logic eo);
        vec_t v;
        v.rst = rst; v.na = na; v.jam = j; v.mem = m; v.az = az; v.mbr = b; v.mv = mv;
        v.chk_mpc = cm; v.e_mpc = em; v.e_stall = es; v.e_ovr = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit model_stall();
        if (!reset) return 1'b0;
        if (m_wait) return !mbr_valid;
        return jam[2] && m_pend && !mbr_valid;
    endfunction

    function automatic int model_nxt();
        int hi, lo;
        hi = ((next_addr >= 9'd256) || (jam[1] && m_n) || (jam[0] && m_z)) ? 256 : 0;
        lo = int'(next_addr) % 256;
        if (jam[2]) lo = lo | int'(mbr);
        return hi + lo;
    endfunction

    task automatic model_step();
        bit st;
        st = model_stall();
        m_last_stall = st;
        if (!reset) begin
            m_mpc = 0; m_n = 1'b0; m_z = 1'b0; m_pend = 1'b0; m_wait = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (!st) begin
                m_mpc = model_nxt();
                m_n = alu_n;
                m_z = alu_z;
            end
            if (mem[0] && !st) m_pend = 1'b1;
            else if (mbr_valid) m_pend = 1'b0;
            m_wait = st;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then step past the rising edge.
    task automatic run_cycle(input bit use_tbl, input int idx);
        bit es, eo;
        @(negedge clk);
        if (m_valid) begin
            es = model_stall();
            eo = reset && mem[0] && m_pend && !mbr_valid && !es;
            chk("model_mpc", 32'(mpc), 32'(m_mpc));
            chk("model_stall", 32'(stall), 32'(es));
            chk("model_rom_read", 32'(rom_read), 32'(!es));
            chk("model_overrun", 32'(fetch_overrun), 32'(eo));
        end
        if (use_tbl) begin
            if (tbl[idx].chk_mpc) chk($sformatf("tbl%0d_mpc", idx), 32'(mpc), 32'(tbl[idx].e_mpc));
            chk($sformatf("tbl%0d_stall", idx), 32'(stall), 32'(tbl[idx].e_stall));
            chk($sformatf("tbl%0d_rom_read", idx), 32'(rom_read), 32'(!tbl[idx].e_stall));
            chk($sformatf("tbl%0d_overrun", idx), 32'(fetch_overrun), 32'(tbl[idx].e_ovr));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_mpc = 0; m_n = 1'b0; m_z = 1'b0; m_pend = 1'b0; m_wait = 1'b0;
        m_valid = 1'b0; m_last_stall = 1'b0;

        //               rst   na      jam     mem     az    mbr    mv    cm    e_mpc   es    eo
        tbl[0]  = mk(1'b0, 9'h000, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 9'h000, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 9'h000, 3'b000, 3'b000, 1'b1, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 9'h012, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 9'h000, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h112, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 9'h012, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h60, 1'b0, 1'b1, 9'h012, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 9'h020, 3'b000, 3'b001, 1'b0, 8'h00, 1'b0, 1'b1, 9'h060, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h020, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h020, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h020, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'hA7, 1'b1, 1'b1, 9'h020, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 9'h030, 3'b000, 3'b001, 1'b0, 8'h00, 1'b0, 1'b1, 9'h0A7, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 9'h031, 3'b000, 3'b001, 1'b0, 8'h00, 1'b0, 1'b1, 9'h030, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 9'h032, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h031, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h55, 1'b0, 1'b1, 9'h032, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 9'h000, 3'b100, 3'b000, 1'b0, 8'h55, 1'b0, 1'b1, 9'h032, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h44, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 9'h001, 3'b100, 3'b001, 1'b0, 8'h10, 1'b0, 1'b1, 9'h044, 1'b0, 1'b0);
        tbl[19] = mk(1'b1, 9'h002, 3'b000, 3'b000, 1'b0, 8'h99, 1'b1, 1'b1, 9'h011, 1'b0, 1'b0);
        tbl[20] = mk(1'b1, 9'h000, 3'b100, 3'b000, 1'b0, 8'h22, 1'b0, 1'b1, 9'h002, 1'b0, 1'b0);
        tbl[21] = mk(1'b1, 9'h000, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0);

        reset = 1'b0; next_addr = 9'h000; jam = 3'b000; mem = 3'b000;
        alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00; mbr_valid = 1'b0;

        for (int i = 0; i < NTBL; i++) begin
            reset = tbl[i].rst; next_addr = tbl[i].na; jam = tbl[i].jam; mem = tbl[i].mem;
            alu_n = 1'b0; alu_z = tbl[i].az; mbr = tbl[i].mbr; mbr_valid = tbl[i].mv;
            run_cycle(1'b1, i);
        end

        // Randomized traffic; the microinstruction is held while the ROM is stalled.
        for (int c = 0; c < 3000; c++) begin
            if (!m_last_stall) begin
                next_addr = 9'($urandom);
                jam       = 3'($urandom);
                mem       = ($urandom_range(2) == 0) ? 3'b001 : 3'($urandom) & 3'b110;
                alu_n     = 1'($urandom);
                alu_z     = 1'($urandom);
            end
            mbr       = 8'($urandom);
            mbr_valid = ($urandom_range(3) == 0);
            reset     = ($urandom_range(99) != 0);
            run_cycle(1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
